mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register. Consumes the EX/MEM register outputs.
//  Performs the data-memory access over a req/ack handshake and stalls upstream while it waits.
//  Presents one registered write-back beat per retired instruction to the register file.
// PARAMETERS
//  DATA_W      64  datapath / memory word width
//  REG_AW      5   destination register index width
//  MEM_TIMEOUT 16  max cycles in ACCESS without dm_ack before abort (>=2)
// PORTS
//  clk             in   1        clock, all state on rising edge
//  reset           in   1        synchronous, active-high
//  exm_valid       in   1        EX/MEM holds a valid instruction
//  exm_alu_result  in   DATA_W   ALU result / memory address
//  exm_write_data  in   DATA_W   store data
//  exm_rd          in   REG_AW   destination register
//  exm_reg_write   in   1        instruction writes rd
//  exm_mem_read    in   1        load
//  exm_mem_write   in   1        store (mem_read and mem_write never both 1)
//  exm_stall       out  1        upstream must hold EX/MEM contents
//  dm_req          out  1        memory request
//  dm_we           out  1        1=store, 0=load
//  dm_addr         out  DATA_W   doubleword address
//  dm_wdata        out  DATA_W   store data
//  dm_rdata        in   DATA_W   load data, valid with dm_ack
//  dm_ack          in   1        single-cycle completion
//  wb_valid        out  1        one-cycle retire pulse
//  wb_reg_write    out  1        write enable to register file
//  wb_rd           out  REG_AW   write-back register
//  wb_data         out  DATA_W   write-back value
//  mem_err         out  1        sticky: misaligned access or timeout
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0; all outputs 0, including exm_stall, dm_*, wb_*, and mem_err.
//  States: IDLE, ACCESS. exm_stall = (state==ACCESS), driven combinationally.
//  IDLE, exm_valid=0: next cycle wb_valid=0 (bubble passes through).
//  IDLE, exm_valid=1, no mem op: latch the instruction; next cycle wb_valid=1, wb_data=alu_result.
//    Latency is 1 cycle.
//  IDLE, mem op, addr[2:0]!=0: no request is issued.
//    Next cycle wb_valid=1, wb_reg_write=0, mem_err<=1.
//  IDLE, mem op, aligned: latch addr, wdata, we, rd, and ctrl; enter ACCESS; counter<=0.
//    dm_req=1 from the next cycle.
//  ACCESS: dm_req, dm_we, dm_addr, and dm_wdata stay registered and stable until the ack cycle inclusive.
//  ACCESS, dm_ack=1: capture dm_rdata for a load; return to IDLE. dm_req=0 next cycle.
//    wb_valid=1 next cycle. Load: wb_data=rdata. Store: wb_reg_write=0, wb_data=0.
//  ACCESS, no ack: counter++. At counter==MEM_TIMEOUT-1 with no ack, abort:
//    IDLE next cycle, dm_req=0, wb_valid=1 with wb_reg_write=0, mem_err<=1.
//  If dm_ack arrives in the timeout cycle, ack wins: normal completion, no error.
//  Instruction accepted at the stall-release cycle: the first IDLE cycle after ACCESS accepts
//    the held EX/MEM instruction. No instruction is lost or duplicated.
//  wb_reg_write = exm_reg_write & (rd!=0) & no error. wb_rd/wb_data are 0 when wb_valid=0.
//  wb_valid is never high for 2 cycles for the same instruction.
//  dm_ack while IDLE is ignored.
//  Reset mid-ACCESS: the in-flight instruction is discarded without retiring; dm_req=0 next cycle.
//    mem_err is cleared. A late dm_ack is ignored.
//  mem_err clears only on reset.
// TESTING
//  ALU op: alu=0x2A, rd=3, reg_write=1 -> next cycle wb_valid=1, rd=3, data=0x2A, stall never 1.
//  Load: addr=0x100, ack after 3 cycles with rdata=0xDEADBEEF
//    -> dm_req high 3 cycles, stall high 3 cycles, wb_data=0xDEADBEEF one cycle after ack.
//  Store: addr=0x08, wdata=0x55, immediate ack -> dm_we=1, wdata=0x55, wb_valid=1 with wb_reg_write=0.
//  Misaligned load at addr=0x104 -> dm_req stays 0, wb_reg_write=0, mem_err=1 and stays 1.
//  No ack for MEM_TIMEOUT=16 cycles -> dm_req drops after 16 cycles, mem_err=1.
//    With ack in cycle 16 instead -> normal retire, mem_err=0.
//  Reset in 2nd ACCESS cycle, then ack -> no wb_valid, all outputs 0, next ALU op retires normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory stage plus MEM/WB pipeline register. Takes the EX/MEM register
//   outputs and forwards ALU results directly. It runs loads and stores over
//   a req/ack data-memory handshake and holds EX/MEM stalled while waiting.
//   It presents one registered write-back beat per retired instruction.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   exm_*             EX/MEM register contents (valid, result/address,
//                     store data, rd, reg_write, mem_read, mem_write)
//   exm_stall         upstream must hold EX/MEM (high while in ACCESS)
//   dm_req/we/addr/wdata   registered data-memory request
//   dm_rdata, dm_ack  memory response (single-cycle ack, rdata with ack)
//   wb_valid          one-cycle retire pulse
//   wb_reg_write      register-file write enable
//   wb_rd, wb_data    write-back register and value (0 when wb_valid=0)
//   mem_err           sticky misaligned-access / timeout flag
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exm_valid,
    input  logic [DATA_W-1:0] exm_alu_result,
    input  logic [DATA_W-1:0] exm_write_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic              exm_mem_read,
    input  logic              exm_mem_write,
    output logic              exm_stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Held request and the instruction's destination/control while in ACCESS
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;

    // MEM/WB register
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              mem_err_q, mem_err_d;

    logic              mem_op;
    logic              misaligned;

    assign mem_op     = exm_mem_read | exm_mem_write;
    assign misaligned = (exm_alu_result[2:0] != 3'b000);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_d           = rd_q;
        rw_d           = rw_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = '0;
        wb_data_d      = '0;
        mem_err_d      = mem_err_q;

        case (state_q)
            ST_IDLE: begin
                if (exm_valid) begin
                    if (!mem_op) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = exm_rd;
                        wb_data_d      = exm_alu_result;
                        wb_reg_write_d = exm_reg_write & (exm_rd != '0);
                    end else if (misaligned) begin
                        // Retire without touching memory; no register write
                        wb_valid_d = 1'b1;
                        wb_rd_d    = exm_rd;
                        mem_err_d  = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = exm_mem_write;
                        addr_d  = exm_alu_result;
                        wdata_d = exm_write_data;
                        rd_d    = exm_rd;
                        rw_d    = exm_reg_write;
                    end
                end
            end

            ST_ACCESS: begin
                if (dm_ack) begin
                    // Ack has priority over the timeout in the same cycle
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = '0;
                    wdata_d    = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (!we_q) begin
                        wb_data_d      = dm_rdata;
                        wb_reg_write_d = rw_q & (rd_q != '0);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = '0;
                    wdata_d    = '0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            rw_q           <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rd_q           <= rd_d;
            rw_q           <= rw_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign exm_stall    = (state_q == ST_ACCESS);
    assign dm_req       = req_q;
    assign dm_we        = we_q;
    assign dm_addr      = addr_q;
    assign dm_wdata     = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Drives an EX/MEM register model, a randomized memory responder and a
//   write-back scoreboard around mem_wb_stage. Expected beats are computed
//   from the instruction and the chosen memory latency at issue time.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int unsigned DATA_W      = 64;
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned MEM_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              exm_valid = 1'b0;
    logic [DATA_W-1:0] exm_alu_result = '0;
    logic [DATA_W-1:0] exm_write_data = '0;
    logic [REG_AW-1:0] exm_rd = '0;
    logic              exm_reg_write = 1'b0;
    logic              exm_mem_read = 1'b0;
    logic              exm_mem_write = 1'b0;
    logic              exm_stall;
    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata = '0;
    logic              dm_ack = 1'b0;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mem_err;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .exm_valid     (exm_valid),
        .exm_alu_result(exm_alu_result),
        .exm_write_data(exm_write_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_mem_read  (exm_mem_read),
        .exm_mem_write (exm_mem_write),
        .exm_stall     (exm_stall),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .dm_ack        (dm_ack),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_err       (mem_err)
    );

    typedef struct {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic [DATA_W-1:0] data;
        logic              err;
        logic              chk_rd;
        logic              chk_data;
    } beat_t;

    typedef struct {
        logic [DATA_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int unsigned       lat;
    } req_t;

    beat_t beat_q[$];
    req_t  req_q[$];

    int   errors = 0;
    int   checks = 0;
    logic exp_err = 1'b0;
    bit   mon_en = 1'b0;
    bit   resp_en = 1'b1;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_stall"}, exm_stall, 1'b0);
        chk1({tag, "_dm_req"}, dm_req, 1'b0);
        chk1({tag, "_dm_we"}, dm_we, 1'b0);
        chk({tag, "_dm_addr"}, dm_addr, '0);
        chk({tag, "_dm_wdata"}, dm_wdata, '0);
        chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk1({tag, "_wb_reg_write"}, wb_reg_write, 1'b0);
        chk({tag, "_wb_rd"}, DATA_W'(wb_rd), '0);
        chk({tag, "_wb_data"}, wb_data, '0);
        chk1({tag, "_mem_err"}, mem_err, 1'b0);
    endtask

    // Present one EX/MEM entry, record what it must produce, and hold it
    // until the stage accepts it (stall low at a rising edge).
    task automatic issue(input logic valid, input logic ld, input logic st_op,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wdat,
                         input logic [REG_AW-1:0] rd, input logic rw,
                         input int unsigned lat, input logic [DATA_W-1:0] rdata);
        beat_t       b;
        req_t        r;
        int unsigned n;
        logic        st;
        if (valid) begin
            b.rd = rd; b.reg_write = 1'b0; b.data = '0; b.err = 1'b0;
            b.chk_rd = 1'b1; b.chk_data = 1'b1;
            if (!ld && !st_op) begin
                b.reg_write = rw && (rd != 0);
                b.data      = alu;
            end else if (alu % 8 != 0) begin
                b.err = 1'b1; b.chk_rd = 1'b0; b.chk_data = 1'b0;
            end else begin
                r.addr = alu; r.we = st_op; r.wdata = wdat; r.rdata = rdata; r.lat = lat;
                req_q.push_back(r);
                if (lat > MEM_TIMEOUT) begin
                    b.err = 1'b1; b.chk_rd = 1'b0; b.chk_data = 1'b0;
                end else if (st_op) begin
                    b.chk_rd = 1'b0;
                end else begin
                    b.reg_write = rw && (rd != 0);
                    b.data      = rdata;
                end
            end
            beat_q.push_back(b);
        end
        exm_valid = valid; exm_mem_read = ld; exm_mem_write = st_op;
        exm_alu_result = alu; exm_write_data = wdat; exm_rd = rd; exm_reg_write = rw;
        n = 0;
        forever begin
            @(negedge clk);
            st = exm_stall;
            @(posedge clk);
            n++;
            if (st === 1'b0) break;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL accept_timeout: stall held %0d cycles, required release by 40", n);
                break;
            end
        end
        #1;
        exm_valid = 1'b0; exm_mem_read = 1'b1; exm_mem_write = 1'b0;
        exm_alu_result = {$urandom, $urandom}; exm_rd = REG_AW'($urandom_range(0, 31));
    endtask

    // Write-back monitor / scoreboard
    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wb_valid === 1'b1) begin
                    if (beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_wb: wb_valid=1 rd=%0d data=0x%0h, required no beat at %0t",
                                 wb_rd, wb_data, $time);
                    end else begin
                        b = beat_q.pop_front();
                        chk1("wb_reg_write", wb_reg_write, b.reg_write);
                        if (b.chk_rd)   chk("wb_rd", DATA_W'(wb_rd), DATA_W'(b.rd));
                        if (b.chk_data) chk("wb_data", wb_data, b.data);
                        if (b.err) exp_err = 1'b1;
                    end
                end else begin
                    chk1("wb_valid_idle", wb_valid, 1'b0);
                    chk1("wb_reg_write_idle", wb_reg_write, 1'b0);
                    chk("wb_rd_idle", DATA_W'(wb_rd), '0);
                    chk("wb_data_idle", wb_data, '0);
                end
                chk1("mem_err", mem_err, exp_err);
            end
        end
    end

    // Data-memory responder: acks the Lth request cycle, checks request fields
    initial begin : responder
        bit          in_txn;
        int unsigned cnt;
        int unsigned exp_len;
        req_t        cur;
        in_txn = 1'b0;
        cnt = 0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (resp_en && mon_en) begin
                dm_ack   = 1'b0;
                dm_rdata = {$urandom, $urandom};
                if (dm_req === 1'b1) begin
                    if (!in_txn) begin
                        if (req_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_req: dm_req=1 addr=0x%0h, required 0", dm_addr);
                            cur = '{default: '0};
                        end else begin
                            cur = req_q.pop_front();
                        end
                        in_txn = 1'b1;
                        cnt = 0;
                    end
                    cnt++;
                    chk1("stall_in_access", exm_stall, 1'b1);
                    chk("dm_addr", dm_addr, cur.addr);
                    chk1("dm_we", dm_we, cur.we);
                    if (cur.we) chk("dm_wdata", dm_wdata, cur.wdata);
                    if (cnt == cur.lat) begin
                        dm_ack   = 1'b1;
                        dm_rdata = cur.rdata;
                    end
                end else begin
                    chk1("stall_idle", exm_stall, 1'b0);
                    if (in_txn) begin
                        exp_len = (cur.lat < MEM_TIMEOUT) ? cur.lat : MEM_TIMEOUT;
                        chk("req_cycles", DATA_W'(cnt), DATA_W'(exp_len));
                        in_txn = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned       n;
        int unsigned       kind;
        logic [DATA_W-1:0] a;
        reset = 1'b1;
        exm_valid = 1'b1;
        exm_alu_result = 64'h1234;
        exm_rd = 5'd7;
        exm_reg_write = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exm_valid = 1'b0;
        mon_en = 1'b1;

        issue(1'b1, 1'b0, 1'b0, 64'h2A, 64'h0, 5'd3, 1'b1, 0, 64'h0);
        issue(1'b1, 1'b1, 1'b0, 64'h100, 64'h0, 5'd5, 1'b1, 3, 64'hDEADBEEF);
        issue(1'b1, 1'b0, 1'b1, 64'h08, 64'h55, 5'd7, 1'b1, 1, 64'h0);
        issue(1'b1, 1'b1, 1'b0, 64'h200, 64'h0, 5'd9, 1'b1, MEM_TIMEOUT, 64'hCAFE_F00D_1234_5678);
        issue(1'b1, 1'b0, 1'b0, 64'h99, 64'h0, 5'd0, 1'b1, 0, 64'h0);
        issue(1'b0, 1'b1, 1'b0, 64'h300, 64'h0, 5'd2, 1'b1, 1, 64'h0);
        issue(1'b1, 1'b1, 1'b0, 64'h104, 64'h0, 5'd4, 1'b1, 1, 64'h0);
        issue(1'b1, 1'b1, 1'b0, 64'h300, 64'h0, 5'd6, 1'b1, MEM_TIMEOUT + 1, 64'h0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 4);
            a = {$urandom, $urandom};
            if (kind >= 3) begin
                if ($urandom_range(0, 7) != 0) a[2:0] = 3'b000;
                else a[2:0] = 3'($urandom_range(1, 7));
            end
            issue(kind != 0, kind == 3, kind == 4, a, {$urandom, $urandom},
                  REG_AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, MEM_TIMEOUT + 3), {$urandom, $urandom});
        end

        n = 0;
        while ((beat_q.size() != 0 || req_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_beats", DATA_W'(beat_q.size()), '0);
        chk("drain_reqs", DATA_W'(req_q.size()), '0);

        // Reset during the second ACCESS cycle, followed by a late ack
        resp_en = 1'b0;
        dm_ack = 1'b0;
        exm_valid = 1'b1; exm_mem_read = 1'b1; exm_mem_write = 1'b0;
        exm_alu_result = 64'h400; exm_rd = 5'd4; exm_reg_write = 1'b1;
        @(posedge clk);
        #1;
        exm_valid = 1'b0;
        @(negedge clk);
        chk1("rst_access_req", dm_req, 1'b1);
        chk1("rst_access_stall", exm_stall, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_err = 1'b0;
        dm_ack = 1'b1;
        dm_rdata = 64'h5A5A;
        @(negedge clk);
        chk_all_zero("post_reset");
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("late_ack_req", dm_req, 1'b0);
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 64'h77, 64'h0, 5'd6, 1'b1, 0, 64'h0);
        n = 0;
        while (beat_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("final_beats", DATA_W'(beat_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
